// File: rtl/urv_defs_pkg.sv
// Shared definitions for the uRV machine-mode trap controller:
// CSR addresses, cause codes, CSR bit positions and the FSM state type.
package urv_defs;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_MTIMER = 4'd7;
    localparam logic [3:0] CAUSE_MEXT   = 4'd11;

    // Bit positions inside mstatus / mie / mip
    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MTIX = 7;
    localparam int BIT_MEIX = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_REFILL
    } trap_state_e;

    // mcause layout: interrupt flag in the MSB, code in the low nibble
    function automatic logic [31:0] mcause_word(input logic intr, input logic [3:0] code);
        return {intr, 27'b0, code};
    endfunction

endpackage

// File: rtl/urv_irq_prio.sv
// Fixed-priority interrupt encoder: external interrupt beats timer interrupt.
// Inputs are already masked (mip & mie).
module urv_irq_prio
    import urv_defs::*;
(
    input  logic       meip_i,
    input  logic       mtip_i,
    output logic       pending_o,
    output logic [3:0] code_o
);

    // Pick the highest-priority enabled interrupt
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pending_o = 1'b0;
        code_o    = 4'd0;
        if (meip_i) begin
            pending_o = 1'b1;
            code_o    = CAUSE_MEXT;
        end else if (mtip_i) begin
            pending_o = 1'b1;
            code_o    = CAUSE_MTIMER;
        end
    end

endmodule

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller for uRV: owns mstatus/mie/mip/mepc/mcause,
// takes sync exceptions and interrupts, executes mret and redirects fetch.
// Build option: URV_TIMER_IRQ_EN enables the timer interrupt (MTIP/MTIE).
module urv_trap_ctrl
    import urv_defs::*;
#(
    parameter logic [31:0] g_trap_vector   = 32'h8,
    parameter int unsigned g_refill_cycles = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_valid_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_is_csr_i,
    input  logic [11:0] x_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        irq_i,
    input  logic        timer_irq_i,
    output logic        f_redirect_o,
    output logic [31:0] f_redirect_pc_o,
    output logic        x_trap_taken_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
);

    localparam logic [2:0] REFILL_INIT = 3'(g_refill_cycles - 1);

    trap_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mip_meip_q, mip_meip_d;
    logic        mip_mtip_q, mip_mtip_d;
    logic [31:2] mepc_q, mepc_d;
    logic        mcause_intr_q, mcause_intr_d;
    logic [3:0]  mcause_code_q, mcause_code_d;

    logic        commit;
    logic        exc_take;
    logic        irq_take;
    logic        trap;
    logic        mret_take;
    logic        csr_we;
    logic        irq_pending;
    logic [3:0]  irq_code;

    // The low PC bits never reach mepc (word-aligned)
    logic [1:0]  unused_pc_lsb;
    assign unused_pc_lsb = x_pc_i[1:0];

`ifndef URV_TIMER_IRQ_EN
    logic unused_timer_irq;
    assign unused_timer_irq = timer_irq_i;
`endif

    urv_irq_prio u_irq_prio (
        .meip_i   (mip_meip_q & mie_meie_q),
        .mtip_i   (mip_mtip_q & mie_mtie_q),
        .pending_o(irq_pending),
        .code_o   (irq_code)
    );

    // Event qualification; all decisions use the registered (pre-write) CSR values
    assign commit    = !x_stall_i && !x_kill_i;
    assign exc_take  = x_exception_i && commit;
    assign irq_take  = mstatus_mie_q && irq_pending && (state_q == ST_IDLE)
                       && x_valid_i && !x_stall_i;
    assign trap      = exc_take || irq_take;
    assign mret_take = x_is_mret_i && commit && !trap;
    assign csr_we    = x_is_csr_i && commit && !trap && !mret_take;

    // Next-state: redirect FSM, trap entry, mret and CSR writes in priority order
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        redirect_pc_d  = redirect_pc_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mepc_d         = mepc_q;
        mcause_intr_d  = mcause_intr_q;
        mcause_code_d  = mcause_code_q;
        mip_meip_d     = irq_i;
`ifdef URV_TIMER_IRQ_EN
        mip_mtip_d     = timer_irq_i;
`else
        mip_mtip_d     = 1'b0;
`endif

        unique case (state_q)
            ST_TRAP: begin
                state_d = ST_REFILL;
                cnt_d   = REFILL_INIT;
            end
            ST_REFILL: begin
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: ;
        endcase

        if (trap) begin
            mepc_d         = x_pc_i[31:2];
            mcause_intr_d  = !exc_take;
            mcause_code_d  = exc_take ? x_exception_cause_i : irq_code;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            state_d        = ST_TRAP;
            redirect_pc_d  = g_trap_vector;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            state_d        = ST_TRAP;
            redirect_pc_d  = {mepc_q, 2'b00};
        end else if (csr_we) begin
            unique case (x_csr_sel_i)
                CSR_ID_MSTATUS: begin
                    mstatus_mie_d  = x_csr_write_value_i[BIT_MIE];
                    mstatus_mpie_d = x_csr_write_value_i[BIT_MPIE];
                end
                CSR_ID_MIE: begin
                    mie_meie_d = x_csr_write_value_i[BIT_MEIX];
`ifdef URV_TIMER_IRQ_EN
                    mie_mtie_d = x_csr_write_value_i[BIT_MTIX];
`endif
                end
                CSR_ID_MEPC: mepc_d = x_csr_write_value_i[31:2];
                CSR_ID_MCAUSE: begin
                    mcause_intr_d = x_csr_write_value_i[31];
                    mcause_code_d = x_csr_write_value_i[3:0];
                end
                default: ;
            endcase
        end
    end

    // State and CSR registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            redirect_pc_q  <= 32'd0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mepc_q         <= 30'd0;
            mcause_intr_q  <= 1'b0;
            mcause_code_q  <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            redirect_pc_q  <= redirect_pc_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mip_meip_q     <= mip_meip_d;
            mip_mtip_q     <= mip_mtip_d;
            mepc_q         <= mepc_d;
            mcause_intr_q  <= mcause_intr_d;
            mcause_code_q  <= mcause_code_d;
        end
    end

    assign x_trap_taken_o  = trap;
    assign f_redirect_o    = (state_q == ST_TRAP);
    assign f_redirect_pc_o = (state_q == ST_TRAP) ? redirect_pc_q : 32'd0;

    always_comb begin
        csr_mstatus_o           = 32'd0;
        csr_mstatus_o[BIT_MIE]  = mstatus_mie_q;
        csr_mstatus_o[BIT_MPIE] = mstatus_mpie_q;
        csr_mie_o               = 32'd0;
        csr_mie_o[BIT_MEIX]     = mie_meie_q;
        csr_mie_o[BIT_MTIX]     = mie_mtie_q;
        csr_mip_o               = 32'd0;
        csr_mip_o[BIT_MEIX]     = mip_meip_q;
        csr_mip_o[BIT_MTIX]     = mip_mtip_q;
    end

    assign csr_mepc_o   = {mepc_q, 2'b00};
    assign csr_mcause_o = mcause_word(mcause_intr_q, mcause_code_q);

endmodule
